// File: rtl/key_load_ctrl.sv
// -----------------------------------------------------------------------------
// key_load_ctrl
//
// Sequential key-delivery controller for a logic-locked core. A key is
// streamed in as CHUNK_WIDTH-bit beats (most significant chunk first),
// followed by one check chunk equal to the XOR-fold of all key chunks.
// The key bus only carries the streamed key after a successful check;
// otherwise it carries DECOY_KEY. Failed checks are counted, and MAX_FAIL
// failures lock the controller until reset.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   load_start  in   one-cycle request to begin / restart a key load
//   in_valid    in   stream beat valid
//   in_ready    out  stream beat ready (decoded from state)
//   in_data     in   key chunk, or the trailing check chunk
//   key_out     out  key bus to the locked core (registered)
//   key_valid   out  key_out holds a verified key (registered)
//   busy        out  loading or checking (decoded from state)
//   err         out  one-cycle pulse after a failed check (registered)
//   lockout     out  sticky lockout flag (registered)
//   fail_cnt    out  failed checks since last success or reset (registered)
// -----------------------------------------------------------------------------
module key_load_ctrl #(
  parameter int                    KEY_WIDTH   = 16,
  parameter int                    CHUNK_WIDTH = 4,
  parameter logic [KEY_WIDTH-1:0]  DECOY_KEY   = '0,
  parameter int                    MAX_FAIL    = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_start,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [CHUNK_WIDTH-1:0]           in_data,
  output logic [KEY_WIDTH-1:0]             key_out,
  output logic                             key_valid,
  output logic                             busy,
  output logic                             err,
  output logic                             lockout,
  output logic [$clog2(MAX_FAIL+1)-1:0]    fail_cnt
);

  localparam int NCHUNKS = KEY_WIDTH / CHUNK_WIDTH;
  localparam int NBEATS  = NCHUNKS + 1;
  localparam int CNT_W   = $clog2(NBEATS);
  localparam int FAIL_W  = $clog2(MAX_FAIL + 1);

  localparam logic [CNT_W-1:0]  LAST_BEAT  = CNT_W'(NBEATS - 1);
  localparam logic [FAIL_W-1:0] FAIL_LIMIT = FAIL_W'(MAX_FAIL);

  // Parameter sanity: the key must split into whole chunks, and at least
  // one failure must be tolerated before lockout can be reached.
  if (KEY_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_chunk
    $error("key_load_ctrl: CHUNK_WIDTH must divide KEY_WIDTH exactly");
  end
  if (MAX_FAIL < 1) begin : g_bad_max_fail
    $error("key_load_ctrl: MAX_FAIL must be at least 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_ARMED,
    ST_LOCKOUT
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       beat_cnt_q;
  logic [KEY_WIDTH-1:0]   shift_q;
  logic [CHUNK_WIDTH-1:0] check_q;
  logic [KEY_WIDTH-1:0]   key_out_q;
  logic                   key_valid_q;
  logic                   err_q;
  logic                   lockout_q;
  logic [FAIL_W-1:0]      fail_cnt_q;

  logic [KEY_WIDTH-1:0]   shift_d;
  logic [FAIL_W-1:0]      fail_cnt_d;
  logic [CHUNK_WIDTH-1:0] fold;

  // Split the assembled key into its chunks; the fold is the XOR of all.
  logic [CHUNK_WIDTH-1:0] chunk_w [NCHUNKS];

  for (genvar gi = 0; gi < NCHUNKS; gi++) begin : g_chunk
    assign chunk_w[gi] = shift_q[gi*CHUNK_WIDTH +: CHUNK_WIDTH];
  end

  always_comb begin
    fold = '0;
    for (int i = 0; i < NCHUNKS; i++) begin
      fold = fold ^ chunk_w[i];
    end
  end

  // New chunk enters at the bottom so the first (MSB) chunk ends up on top.
  // Written as a shift rather than a slice so KEY_WIDTH == CHUNK_WIDTH works.
  assign shift_d = (shift_q << CHUNK_WIDTH) | KEY_WIDTH'(in_data);

  // Saturating increment; lockout normally stops counting first, the
  // saturation just guarantees the counter can never wrap.
  assign fail_cnt_d = (fail_cnt_q == FAIL_LIMIT) ? fail_cnt_q
                                                 : fail_cnt_q + FAIL_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      shift_q     <= '0;
      check_q     <= '0;
      key_out_q   <= DECOY_KEY;
      key_valid_q <= 1'b0;
      err_q       <= 1'b0;
      lockout_q   <= 1'b0;
      fail_cnt_q  <= '0;
    end else begin
      // err is a single-cycle pulse; only a failing CHECK raises it.
      err_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (load_start) begin
            state_q    <= ST_LOAD;
            beat_cnt_q <= '0;
            shift_q    <= '0;
          end
        end

        ST_LOAD: begin
          if (load_start) begin
            // Restart wins over a beat presented in the same cycle.
            beat_cnt_q <= '0;
            shift_q    <= '0;
          end else if (in_valid) begin
            if (beat_cnt_q == LAST_BEAT) begin
              check_q <= in_data;
              state_q <= ST_CHECK;
            end else begin
              shift_q    <= shift_d;
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end

        ST_CHECK: begin
          if (fold == check_q) begin
            state_q     <= ST_ARMED;
            key_out_q   <= shift_q;
            key_valid_q <= 1'b1;
            fail_cnt_q  <= '0;
          end else begin
            err_q      <= 1'b1;
            fail_cnt_q <= fail_cnt_d;
            if (fail_cnt_d == FAIL_LIMIT) begin
              state_q   <= ST_LOCKOUT;
              lockout_q <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          // Do not keep key material around once it has been judged.
          shift_q    <= '0;
          beat_cnt_q <= '0;
        end

        ST_ARMED: begin
          if (load_start) begin
            // Withdraw the old key immediately so it is never visible
            // while the replacement is being streamed in.
            state_q     <= ST_LOAD;
            beat_cnt_q  <= '0;
            shift_q     <= '0;
            key_out_q   <= DECOY_KEY;
            key_valid_q <= 1'b0;
          end
        end

        ST_LOCKOUT: begin
          // Terminal until reset; hold the safe output values.
          key_out_q   <= DECOY_KEY;
          key_valid_q <= 1'b0;
          lockout_q   <= 1'b1;
        end

        default: begin
          state_q     <= ST_IDLE;
          key_out_q   <= DECOY_KEY;
          key_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign key_out   = key_out_q;
  assign key_valid = key_valid_q;
  assign err       = err_q;
  assign lockout   = lockout_q;
  assign fail_cnt  = fail_cnt_q;

endmodule

// File: tb/tb_key_load_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for key_load_ctrl: directed scenarios followed by randomized loads.
// The stimulus side predicts each load outcome from the key and check chunk
// and queues it; an independent monitor pops and compares whenever the DUT
// reports an outcome (err pulse or key_valid rising).
// -----------------------------------------------------------------------------
module tb_key_load_ctrl;

  localparam int KW  = 16;
  localparam int CW  = 4;
  localparam int MF  = 3;
  localparam int NCH = KW / CW;
  localparam logic [KW-1:0] DECOY = '0;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [CW-1:0] in_data = '0;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          busy;
  logic          err;
  logic          lockout;
  logic [1:0]    fail_cnt;

  key_load_ctrl #(
    .KEY_WIDTH  (KW),
    .CHUNK_WIDTH(CW),
    .DECOY_KEY  (DECOY),
    .MAX_FAIL   (MF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_start(load_start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err),
    .lockout   (lockout),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Expected outcome of one completed load.
  typedef struct {
    bit            ok;
    logic [KW-1:0] key;
    int            fcnt;
    bit            lock;
    int            cyc;
  } ev_t;

  ev_t exp_q[$];

  // Reference model state.
  int m_fail  = 0;
  bit m_lock  = 0;
  bit m_armed = 0;

  function automatic logic [CW-1:0] ref_fold(input logic [KW-1:0] k);
    logic [CW-1:0] f;
    logic [KW-1:0] t;
    f = '0;
    for (int i = 0; i < NCH; i++) begin
      t = k >> (CW * i);
      f = f ^ t[CW-1:0];
    end
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat after 'gaps' idle cycles; wait (bounded) for acceptance.
  task automatic send_beat(input logic [CW-1:0] d, input int gaps,
                           output bit ok, output int acc);
    int n;
    in_valid = 1'b0;
    repeat (gaps) tick();
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 20) begin
      ok = in_ready;
      tick();
      n++;
    end
    acc = cycle;
    in_valid = 1'b0;
    if (!ok) chk("beat_accept_timeout", 0, 1);
  endtask

  function automatic int pick_gaps(input int mode);
    if (mode == 1) return 1;
    if (mode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  task automatic reset_dut();
    rst_n      = 1'b0;
    load_start = 1'b0;
    in_valid   = 1'b0;
    tick();
    rst_n   = 1'b1;
    m_fail  = 0;
    m_lock  = 0;
    m_armed = 0;
    chk("rst_key_out",   key_out,   DECOY);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_busy",      busy,      0);
    chk("rst_err",       err,       0);
    chk("rst_lockout",   lockout,   0);
    chk("rst_fail_cnt",  fail_cnt,  0);
    chk("rst_in_ready",  in_ready,  0);
    $display("reset applied");
  endtask

  // One complete load attempt: key chunks MSB first, then the check chunk.
  task automatic do_load(input logic [KW-1:0] key, input logic [CW-1:0] chkv,
                         input int gap_mode, input bit restart);
    bit            ok;
    int            acc;
    int            nb;
    logic [KW-1:0] t;
    ev_t           e;

    load_start = 1'b1;
    tick();
    load_start = 1'b0;

    if (m_lock) begin
      in_valid = 1'b1;
      in_data  = chkv;
      repeat (4) begin
        chk("lockout_in_ready",  in_ready,  0);
        chk("lockout_flag",      lockout,   1);
        chk("lockout_key_valid", key_valid, 0);
        tick();
      end
      in_valid = 1'b0;
      $display("load key=%h check=%h ignored (locked out)", key, chkv);
      return;
    end

    if (m_armed) begin
      chk("reload_key_valid_drop", key_valid, 0);
      chk("reload_key_decoy",      key_out,   DECOY);
      m_armed = 0;
    end

    if (restart) begin
      nb = int'($urandom_range(1, NCH));
      for (int i = 0; i < nb; i++) begin
        send_beat(CW'($urandom), pick_gaps(gap_mode), ok, acc);
        if (!ok) return;
      end
      // Restart, possibly with a beat in the same cycle (it must be dropped).
      in_valid   = 1'($urandom_range(0, 1));
      in_data    = CW'($urandom);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      in_valid   = 1'b0;
    end

    for (int i = NCH - 1; i >= 0; i--) begin
      t = key >> (i * CW);
      send_beat(t[CW-1:0], pick_gaps(gap_mode), ok, acc);
      if (!ok) return;
    end
    send_beat(chkv, pick_gaps(gap_mode), ok, acc);
    if (!ok) return;

    // Outcome appears the edge after the check beat is accepted
    // (accepting edge enters CHECK, the next edge resolves it).
    e.cyc = acc + 1;
    if (chkv == ref_fold(key)) begin
      m_fail  = 0;
      m_armed = 1;
      e.ok = 1; e.key = key; e.fcnt = 0; e.lock = 0;
    end else begin
      m_fail = m_fail + 1;
      if (m_fail >= MF) m_lock = 1;
      e.ok = 0; e.key = DECOY; e.fcnt = m_fail; e.lock = m_lock;
    end
    exp_q.push_back(e);
    $display("load key=%h check=%h restart=%0d gaps=%0d expect=%s fail_cnt=%0d",
             key, chkv, restart, gap_mode, e.ok ? "armed" : "rejected", e.fcnt);
    repeat (3) tick();
  endtask

  // Monitor: compare each reported outcome against the queued prediction.
  bit kv_prev  = 1'b0;
  bit err_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (err || (key_valid && !kv_prev)) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_event: err=%0d key_valid=%0d key_out=0x%0h, expected no event",
                   err, key_valid, key_out);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          chk("ev_kind",     err ? 0 : 1, e.ok);
          chk("ev_key_out",  key_out,     e.key);
          chk("ev_key_valid", key_valid,  e.ok);
          chk("ev_fail_cnt", fail_cnt,    e.fcnt);
          chk("ev_lockout",  lockout,     e.lock);
          chk("ev_latency",  cycle,       e.cyc);
        end
      end
      if (err_prev) chk("err_single_cycle", err, 0);
      if (!key_valid) chk("decoy_when_unarmed", key_out, DECOY);
      if (in_ready) chk("busy_with_ready", busy, 1);
    end
    kv_prev  <= key_valid;
    err_prev <= err;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    logic [KW-1:0] k;
    logic [CW-1:0] c;

    reset_dut();

    // Good load, then a bad check on the same key.
    do_load(16'hA5C3, 4'h0, 0, 0);
    chk("good_fail_cnt", fail_cnt, 0);
    do_load(16'hA5C3, 4'h1, 0, 0);
    chk("bad_key_out",  key_out,  DECOY);
    chk("bad_busy",     busy,     0);
    chk("bad_in_ready", in_ready, 0);
    chk("bad_fail_cnt", fail_cnt, 1);

    // Two more failures reach MAX_FAIL and lock; a good load is ignored.
    do_load(16'hA5C3, 4'h1, 0, 0);
    do_load(16'hA5C3, 4'h7, 0, 0);
    chk("lock_after_third", lockout, 1);
    do_load(16'hA5C3, 4'h0, 0, 0);
    reset_dut();

    // Restart mid-load, then a full good load of 0x1234.
    do_load(16'h1234, 4'h4, 0, 1);
    chk("restart_key", key_out, 16'h1234);

    // Armed reload to 0xFFFF, then a gappy load.
    do_load(16'hA5C3, 4'h0, 0, 0);
    do_load(16'hFFFF, 4'h0, 0, 0);
    chk("reload_key", key_out, 16'hFFFF);
    do_load(16'hA5C3, 4'h0, 1, 0);
    chk("gappy_key", key_out, 16'hA5C3);

    // Reset in the middle of a load.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_armed = 0;
    send_beat(4'hA, 0, ok, acc);
    send_beat(4'h5, 0, ok, acc);
    reset_dut();

    // Randomized loads.
    for (int n = 0; n < 60; n++) begin
      k = KW'($urandom);
      c = ref_fold(k);
      if ($urandom_range(0, 9) >= 6) c = c ^ CW'($urandom_range(1, (1 << CW) - 1));
      do_load(k, c, ($urandom_range(0, 1) == 1) ? 2 : 0, $urandom_range(0, 4) == 0);
      if (m_lock && $urandom_range(0, 1) == 1) reset_dut();
    end

    // Let any outstanding outcome drain.
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
